// File: rtl/eros_pkg.sv
// Shared definitions for the EROS safe-CSR window: offsets, unlock keys,
// lock FSM encoding and a byte-enable helper.
package eros_pkg;

  localparam logic [31:0] SAFE_CPU_REGISTER_START_ADDRESS = 32'h2000_0000;

  localparam logic [7:0] SAFE_CSR_OFF_ID       = 8'h00;
  localparam logic [7:0] SAFE_CSR_OFF_LOCK     = 8'h04;
  localparam logic [7:0] SAFE_CSR_OFF_KEY      = 8'h08;
  localparam logic [7:0] SAFE_CSR_OFF_CYCLE    = 8'h0C;
  localparam logic [7:0] SAFE_CSR_OFF_CFG_BASE = 8'h10;

  localparam logic [31:0] SAFE_CSR_KEY1 = 32'h5AFE_0001;
  localparam logic [31:0] SAFE_CSR_KEY2 = 32'h5AFE_0002;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKED   = 2'd1,
    KEY1_OK  = 2'd2
  } safe_lock_state_e;

  function automatic logic [31:0] be_to_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/eros_resp_pipe.sv
// Fixed-latency in-order response pipeline carrying {valid, err, rdata}.
// Data only advances with a valid beat, so the tail holds the last response.
module eros_resp_pipe #(
  parameter int LATENCY = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  input  logic        i_err,
  input  logic [31:0] i_rdata,
  output logic        o_valid,
  output logic        o_err,
  output logic [31:0] o_rdata
);

  logic [LATENCY-1:0]       r_valid;
  logic [LATENCY-1:0]       r_err;
  logic [LATENCY-1:0][31:0] r_rdata;

  // Shift responses one stage per cycle; a reset drops everything in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= '0;
      r_err   <= '0;
      r_rdata <= '0;
    end else begin
      r_valid[0] <= i_valid;
      if (i_valid) begin
        r_err[0]   <= i_err;
        r_rdata[0] <= i_rdata;
      end
      for (int k = 1; k < LATENCY; k++) begin
        r_valid[k] <= r_valid[k-1];
        if (r_valid[k-1]) begin
          r_err[k]   <= r_err[k-1];
          r_rdata[k] <= r_rdata[k-1];
        end
      end
    end
  end

  assign o_valid = r_valid[LATENCY-1];
  assign o_err   = r_err[LATENCY-1];
  assign o_rdata = r_rdata[LATENCY-1];

endmodule

// File: rtl/eros_safe_csr_slave.sv
// OBI responder for the safe-CSR window: ID, key-protected lock, cycle counter
// and N_CFG configuration registers, answered in order after LATENCY cycles.
module eros_safe_csr_slave
  import eros_pkg::*;
#(
  parameter int          N_CFG        = 8,
  parameter int          LATENCY      = 1,
  parameter logic [31:0] ID_VALUE     = 32'h5AFE_0100,
  parameter logic        RESET_LOCKED = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_i,
  output logic                 gnt_o,
  input  logic [31:0]          addr_i,
  input  logic                 we_i,
  input  logic [3:0]           be_i,
  input  logic [31:0]          wdata_i,
  output logic                 rvalid_o,
  output logic [31:0]          rdata_o,
  output logic                 err_o,
  output logic [32*N_CFG-1:0]  cfg_o,
  output logic                 locked_o
);

  localparam safe_lock_state_e RESET_STATE = RESET_LOCKED ? LOCKED : UNLOCKED;

  safe_lock_state_e          r_state;
  logic                      r_locked;
  logic [31:0]               r_cycle;
  logic [N_CFG-1:0][31:0]    r_cfg;

  logic [7:0]  w_off;
  logic [5:0]  w_cfg_word;
  logic [2:0]  w_cfg_idx;
  logic        w_in_win;
  logic        w_cfg_hit;
  logic        w_err;
  logic        w_lock_set;
  logic        w_key_wr;
  logic        w_cfg_we;
  logic [31:0] w_rdata;
  logic [31:0] w_cfg_rdata;
  logic [31:0] w_be_mask;

  assign w_off      = addr_i[7:0];
  assign w_in_win   = (addr_i[31:8] == SAFE_CPU_REGISTER_START_ADDRESS[31:8]) && (addr_i[1:0] == 2'b00);
  assign w_cfg_word = w_off[7:2] - SAFE_CSR_OFF_CFG_BASE[7:2];
  assign w_cfg_idx  = w_cfg_word[2:0];
  assign w_cfg_hit  = (w_off[7:2] >= SAFE_CSR_OFF_CFG_BASE[7:2]) && ({26'd0, w_cfg_word} < 32'(N_CFG));
  assign w_be_mask  = be_to_mask(be_i);

  // CFG read mux over the implemented registers only.
  always_comb begin
    w_cfg_rdata = 32'h0;
    for (int i = 0; i < N_CFG; i++) begin
      w_cfg_rdata = w_cfg_rdata | ((w_cfg_idx == 3'(i)) ? r_cfg[i] : 32'h0);
    end
  end

  // Address decode: read data, error and side-effect strobes for this request.
  always_comb begin
    w_err      = 1'b0;
    w_rdata    = 32'h0;
    w_lock_set = 1'b0;
    w_key_wr   = 1'b0;
    w_cfg_we   = 1'b0;
    if (!w_in_win) begin
      w_err = 1'b1;
    end else begin
      case (w_off)
        SAFE_CSR_OFF_ID: begin
          if (we_i) w_err = 1'b1;
          else      w_rdata = ID_VALUE;
        end
        SAFE_CSR_OFF_LOCK: begin
          if (!we_i)                w_rdata = {31'd0, (r_state != UNLOCKED)};
          else if (be_i != 4'hF)    w_err = 1'b1;
          else                      w_lock_set = wdata_i[0];
        end
        SAFE_CSR_OFF_KEY: begin
          if (we_i && (be_i != 4'hF)) w_err = 1'b1;
          else                        w_key_wr = we_i;
        end
        SAFE_CSR_OFF_CYCLE: begin
          if (we_i) w_err = 1'b1;
          else      w_rdata = r_cycle;
        end
        default: begin
          if (!w_cfg_hit)                 w_err = 1'b1;
          else if (!we_i)                 w_rdata = w_cfg_rdata;
          else if (r_state != UNLOCKED)   w_err = 1'b1;
          else                            w_cfg_we = 1'b1;
        end
      endcase
    end
  end

  // Lock sequencer: a key pair must arrive on consecutive accepted requests.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= RESET_STATE;
      r_locked <= RESET_LOCKED;
    end else if (req_i) begin
      case (r_state)
        UNLOCKED: begin
          if (w_lock_set) begin
            r_state  <= LOCKED;
            r_locked <= 1'b1;
          end
        end
        LOCKED: begin
          if (w_key_wr && (wdata_i == SAFE_CSR_KEY1)) r_state <= KEY1_OK;
        end
        KEY1_OK: begin
          if (w_key_wr && (wdata_i == SAFE_CSR_KEY2)) begin
            r_state  <= UNLOCKED;
            r_locked <= 1'b0;
          end else begin
            r_state  <= LOCKED;
          end
        end
        default: begin
          r_state  <= LOCKED;
          r_locked <= 1'b1;
        end
      endcase
    end
  end

  // Free-running cycle counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_cycle <= 32'h0;
    else         r_cycle <= r_cycle + 32'd1;
  end

  // CFG byte-lane writes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cfg <= '0;
    end else if (req_i && w_cfg_we) begin
      for (int i = 0; i < N_CFG; i++) begin
        if (w_cfg_idx == 3'(i)) r_cfg[i] <= (r_cfg[i] & ~w_be_mask) | (wdata_i & w_be_mask);
      end
    end
  end

  eros_resp_pipe #(.LATENCY(LATENCY)) u_resp_pipe (
    .i_clk   (clk_i),
    .i_rst_n (rst_ni),
    .i_valid (req_i),
    .i_err   (w_err),
    .i_rdata (w_rdata),
    .o_valid (rvalid_o),
    .o_err   (err_o),
    .o_rdata (rdata_o)
  );

  assign gnt_o    = 1'b1;
  assign cfg_o    = r_cfg;
  assign locked_o = r_locked;

endmodule
